// File: rtl/fb_arb_pkg.sv
// -----------------------------------------------------------------------------
// fb_arb_pkg
//
// Shared definitions for the framebuffer arbiter:
//   * default geometry of the framebuffer and the CPU starvation limit
//   * requester_e : who owns an in-flight memory transaction
//   * tag_t       : per-transaction tag carried alongside the RAM read latency
//   * addr_out_of_range : range check shared by RTL that needs it
// -----------------------------------------------------------------------------
package fb_arb_pkg;

    // 640x480 pixels, one byte each.
    localparam int FB_DEPTH_DEFAULT  = 307200;
    localparam int FB_ADDR_W_DEFAULT = 19;
    // Consecutive denied CPU cycles before the CPU is forced in ahead of VGA.
    localparam int MAX_WAIT_DEFAULT  = 4;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VGA  = 2'd1,
        REQ_CPU  = 2'd2
    } requester_e;

    // Travels with every accepted transaction until its response is issued.
    // err marks an out-of-range address: the RAM is never touched and the
    // response data is forced to zero.
    typedef struct packed {
        requester_e who;
        logic       we;
        logic       err;
    } tag_t;

    localparam tag_t TAG_IDLE = '{who: REQ_NONE, we: 1'b0, err: 1'b0};

    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned depth);
        return (addr >= depth);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_arbiter_if
//
// Bundles the three buses seen by the framebuffer arbiter:
//   VGA : vga_req, vga_addr -> vga_gnt, vga_data, vga_valid
//   CPU : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_gnt, cpu_ack,
//         cpu_rdata, cpu_err
//   RAM : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//         (single-port synchronous RAM, one cycle read latency)
//
// Modports:
//   slave  : the arbiter side (receives requests, drives the RAM port)
//   master : the environment side (requesters plus the RAM model)
// -----------------------------------------------------------------------------
interface fb_arbiter_if
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W_DEFAULT
);

    // VGA read port
    logic              vga_req;
    logic [31:0]       vga_addr;
    logic              vga_gnt;
    logic [7:0]        vga_data;
    logic              vga_valid;

    // CPU read/write port
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;
    logic              cpu_err;

    // RAM port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  vga_req, vga_addr,
        output vga_gnt, vga_data, vga_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_ack, cpu_rdata, cpu_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_gnt, vga_data, vga_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_ack, cpu_rdata, cpu_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/arb_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
//
// Counts consecutive cycles in which the CPU is requesting but not granted.
// The count clears whenever the CPU is granted or stops requesting and
// saturates at MAX_WAIT. starve_force is high while the count sits at
// MAX_WAIT, telling the arbiter to let the CPU win over VGA this cycle.
//
// Ports:
//   clk          : clock
//   reset        : synchronous, active low
//   req          : CPU request
//   gnt          : CPU grant (same cycle)
//   starve_force : count has reached MAX_WAIT
// -----------------------------------------------------------------------------
module arb_starve_counter
    import fb_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic starve_force
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (!req || gnt) begin
            count_next = '0;
        end else if (count_reg != CNT_MAX) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign starve_force = (count_reg == CNT_MAX);

endmodule

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//
// Shares one single-port synchronous framebuffer RAM between a VGA scan-out
// reader and a CPU read/write port.
//
// Arbitration (combinational grants):
//   VGA has fixed priority. When the CPU has been denied MAX_WAIT cycles in a
//   row (arb_starve_counter) and is still requesting, the CPU wins instead.
//   Grants are held low while reset is asserted.
//
// Pipeline, for a transaction accepted at edge t:
//   edge t   : RAM command registers and tag stage 0 loaded
//   edge t+1 : RAM samples the command; tag moves to stage 1
//   edge t+2 : mem_rdata captured into the requester's data register and the
//              one-cycle vga_valid / cpu_ack pulse is raised
//   One acceptance per cycle, so responses come back in acceptance order.
//   Out-of-range addresses are accepted but never reach the RAM; their
//   response carries data 0 (and cpu_err for the CPU).
//
// Ports:
//   clk   : clock
//   reset : synchronous, active low; flushes every in-flight transaction
//   bus   : fb_arbiter_if.slave (VGA, CPU and RAM buses)
// -----------------------------------------------------------------------------
module fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int FB_DEPTH  = FB_DEPTH_DEFAULT,
    parameter int FB_ADDR_W = FB_ADDR_W_DEFAULT,
    parameter int MAX_WAIT  = MAX_WAIT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fb_arbiter_if.slave  bus
);

    localparam int TAG_STAGES = 2;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic starve_force;
    logic vga_gnt;
    logic cpu_gnt;

    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk          (clk),
        .reset        (reset),
        .req          (bus.cpu_req),
        .gnt          (cpu_gnt),
        .starve_force (starve_force)
    );

    always_comb begin
        cpu_gnt = reset && bus.cpu_req && (!bus.vga_req || starve_force);
        vga_gnt = reset && bus.vga_req && !cpu_gnt;
    end

    assign bus.vga_gnt = vga_gnt;
    assign bus.cpu_gnt = cpu_gnt;

    // ------------------------------------------------------------------
    // Accepted transaction (valid only when one of the grants is high)
    // ------------------------------------------------------------------
    logic        acc_any;
    logic [31:0] acc_addr;
    logic        acc_err;
    logic        acc_we;
    tag_t        acc_tag;

    always_comb begin
        acc_any  = vga_gnt || cpu_gnt;
        acc_addr = cpu_gnt ? bus.cpu_addr : bus.vga_addr;
        acc_err  = acc_any && addr_out_of_range(acc_addr, FB_DEPTH);
        acc_we   = cpu_gnt && bus.cpu_we;

        acc_tag  = TAG_IDLE;
        if (cpu_gnt) begin
            acc_tag.who = REQ_CPU;
        end else if (vga_gnt) begin
            acc_tag.who = REQ_VGA;
        end
        acc_tag.we  = acc_we;
        acc_tag.err = acc_err;
    end

    // ------------------------------------------------------------------
    // RAM command registers
    // ------------------------------------------------------------------
    logic                 mem_en_reg;
    logic                 mem_we_reg;
    logic [FB_ADDR_W-1:0] mem_addr_reg;
    logic [7:0]           mem_wdata_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            // An out-of-range access keeps the RAM idle, write or read.
            mem_en_reg <= acc_any && !acc_err;
            mem_we_reg <= acc_we && !acc_err;
            if (acc_any) begin
                mem_addr_reg  <= acc_addr[FB_ADDR_W-1:0];
                mem_wdata_reg <= acc_we ? bus.cpu_wdata : 8'h00;
            end
        end
    end

    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;

    // ------------------------------------------------------------------
    // Tag pipeline: stage 0 lines up with the RAM command, stage 1 with the
    // RAM read data. Resetting every stage to REQ_NONE is what discards the
    // in-flight transactions.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < TAG_STAGES; gi++) begin : g_tag
            tag_t tag_reg;
            tag_t tag_in;

            if (gi == 0) begin : g_head
                assign tag_in = acc_tag;
            end else begin : g_body
                assign tag_in = g_tag[gi-1].tag_reg;
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    tag_reg <= TAG_IDLE;
                end else begin
                    tag_reg <= tag_in;
                end
            end
        end
    endgenerate

    tag_t tag_out;
    assign tag_out = g_tag[TAG_STAGES-1].tag_reg;

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    logic       vga_valid_reg;
    logic [7:0] vga_data_reg;
    logic       cpu_ack_reg;
    logic [7:0] cpu_rdata_reg;
    logic       cpu_err_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vga_valid_reg <= 1'b0;
            vga_data_reg  <= '0;
            cpu_ack_reg   <= 1'b0;
            cpu_rdata_reg <= '0;
            cpu_err_reg   <= 1'b0;
        end else begin
            vga_valid_reg <= (tag_out.who == REQ_VGA);
            cpu_ack_reg   <= (tag_out.who == REQ_CPU);
            cpu_err_reg   <= (tag_out.who == REQ_CPU) && tag_out.err;

            // Data registers only move when their requester has a response,
            // so they hold the last returned value between pulses.
            if (tag_out.who == REQ_VGA) begin
                vga_data_reg <= tag_out.err ? 8'h00 : bus.mem_rdata;
            end
            if (tag_out.who == REQ_CPU) begin
                cpu_rdata_reg <= (tag_out.err || tag_out.we) ? 8'h00 : bus.mem_rdata;
            end
        end
    end

    assign bus.vga_valid = vga_valid_reg;
    assign bus.vga_data  = vga_data_reg;
    assign bus.cpu_ack   = cpu_ack_reg;
    assign bus.cpu_rdata = cpu_rdata_reg;
    assign bus.cpu_err   = cpu_err_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
//
// Drives fb_arbiter through directed scenarios (reset, single VGA read, CPU
// write then read-back, sustained contention, out-of-range CPU read, reset
// with reads in flight) followed by randomized traffic with occasional
// resets. A behavioural RAM model answers the RAM port. The driver predicts
// grants from the arbitration rules and queues the expected RAM command and
// response for every acceptance; a monitor on the falling edge pops and
// compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;
    import fb_arb_pkg::*;

    localparam int FB_DEPTH  = 307200;
    localparam int FB_ADDR_W = 19;
    localparam int MAX_WAIT  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_arbiter_if #(.ADDR_W(FB_ADDR_W)) bus ();

    fb_arbiter #(
        .FB_DEPTH  (FB_DEPTH),
        .FB_ADDR_W (FB_ADDR_W),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Initial framebuffer contents, shared by the RAM model and the shadow.
    // ------------------------------------------------------------------
    function automatic logic [7:0] init_pat(input int unsigned a);
        if (a == 294) return 8'h1C;
        return 8'(a * 37 + 5);
    endfunction

    // Behavioural single-port synchronous RAM, one cycle read latency.
    logic [7:0] ram [0:(1<<FB_ADDR_W)-1];
    logic [7:0] ram_rd = 8'h00;
    logic       ram_inited = 1'b0;
    assign bus.mem_rdata = ram_rd;

    always @(posedge clk) begin
        if (!ram_inited) begin
            for (int i = 0; i < FB_DEPTH; i++) ram[i] <= init_pat(i);
            ram_inited <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_rd <= ram[bus.mem_addr];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        int         due;
        logic       is_cpu;
        logic [7:0] data;
        logic       err;
    } resp_t;

    typedef struct {
        int                   due;
        logic                 we;
        logic [FB_ADDR_W-1:0] addr;
        logic [7:0]           wdata;
    } memop_t;

    resp_t      rq[$];
    memop_t     mq[$];
    logic [7:0] shadow [int unsigned];
    int         denied = 0;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] shadow_rd(input int unsigned a);
        if (shadow.exists(a)) return shadow[a];
        return init_pat(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        case (r)
            0:       return 32'(FB_DEPTH) + 32'($urandom_range(0, 999));
            1:       return 32'(FB_DEPTH - 1);
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd294;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    // ------------------------------------------------------------------
    // One clock cycle of stimulus. Called just after a falling edge; the
    // prediction is for the rising edge that follows.
    // ------------------------------------------------------------------
    task automatic step(input logic rst_n, input logic vr, input logic [31:0] va,
                        input logic cr, input logic cw, input logic [31:0] ca,
                        input logic [7:0] cd, output logic gv, output logic gc);
        logic   ev, ec, oor;
        resp_t  r;
        memop_t m;

        reset        = rst_n;
        bus.vga_req  = vr;
        bus.vga_addr = va;
        bus.cpu_req  = cr;
        bus.cpu_we   = cw;
        bus.cpu_addr = ca;
        bus.cpu_wdata = cd;
        #1;

        ec = rst_n && cr && (!vr || denied >= MAX_WAIT);
        ev = rst_n && vr && !ec;
        chk("vga_gnt", 32'(bus.vga_gnt), 32'(ev));
        chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(ec));

        if (!rst_n) begin
            // Everything not yet presented is lost to the reset edge.
            while (rq.size() != 0 && rq[rq.size()-1].due > cyc) void'(rq.pop_back());
            while (mq.size() != 0 && mq[mq.size()-1].due > cyc) void'(mq.pop_back());
            denied = 0;
        end else begin
            if (ev || ec) begin
                logic [31:0] a;
                a   = ec ? ca : va;
                oor = (a >= 32'(FB_DEPTH));
                r.due    = cyc + 3;
                r.is_cpu = ec;
                r.err    = ec && oor;
                if (oor || (ec && cw)) r.data = 8'h00;
                else                   r.data = shadow_rd(a);
                rq.push_back(r);
                if (!oor) begin
                    m.due   = cyc + 1;
                    m.we    = ec && cw;
                    m.addr  = a[FB_ADDR_W-1:0];
                    m.wdata = cd;
                    mq.push_back(m);
                    if (ec && cw) shadow[a] = cd;
                end
            end
            if (cr && !ec) denied = (denied + 1 > MAX_WAIT) ? MAX_WAIT : denied + 1;
            else           denied = 0;
        end
        gv = ev;
        gc = ec;

        @(negedge clk);
        if (!rst_n) begin
            chk("rst_vga_valid", 32'(bus.vga_valid), 32'(0));
            chk("rst_vga_data",  32'(bus.vga_data),  32'(0));
            chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'(0));
            chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
            chk("rst_cpu_err",   32'(bus.cpu_err),   32'(0));
            chk("rst_mem_en",    32'(bus.mem_en),    32'(0));
            chk("rst_mem_we",    32'(bus.mem_we),    32'(0));
            chk("rst_mem_addr",  32'(bus.mem_addr),  32'(0));
            chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares whatever the DUT presents against the queues.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        resp_t  e;
        memop_t m;
        if (bus.vga_valid || bus.cpu_ack) begin
            chk("resp_expected", 32'(rq.size() != 0), 32'(1));
            chk("resp_single", 32'(bus.vga_valid && bus.cpu_ack), 32'(0));
            if (rq.size() != 0) begin
                e = rq.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.due));
                chk("resp_is_cpu", 32'(bus.cpu_ack), 32'(e.is_cpu));
                if (e.is_cpu) begin
                    chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
                    chk("cpu_err",   32'(bus.cpu_err),   32'(e.err));
                end else begin
                    chk("vga_data", 32'(bus.vga_data), 32'(e.data));
                end
            end
        end
        while (rq.size() != 0 && rq[0].due <= cyc) begin
            chk("resp_missing_due", 32'(rq[0].due), 32'(cyc + 1));
            void'(rq.pop_front());
        end
        if (!bus.cpu_ack) chk("cpu_err_idle", 32'(bus.cpu_err), 32'(0));

        if (mq.size() != 0 && mq[0].due == cyc) begin
            m = mq.pop_front();
            chk("mem_en",   32'(bus.mem_en),   32'(1));
            chk("mem_we",   32'(bus.mem_we),   32'(m.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
            if (m.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
        end else begin
            chk("mem_en_idle", 32'(bus.mem_en), 32'(0));
            chk("mem_we_idle", 32'(bus.mem_we), 32'(0));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        gv, gc;
        logic        vp, cp, cw, rn;
        logic [31:0] va, ca;
        logic [7:0]  cd;

        reset = 1'b0;
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        @(negedge clk);

        // Reset held two cycles with both requesters asking, then contention:
        // VGA first, CPU forced in every fifth cycle.
        repeat (2) step(1'b0, 1'b1, 32'd10, 1'b1, 1'b0, 32'd200, 8'h00, gv, gc);
        for (int i = 0; i < 15; i++)
            step(1'b1, 1'b1, 32'(100 + i), 1'b1, 1'b0, 32'd200, 8'h00, gv, gc);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);

        // Single VGA read of the preloaded pixel.
        step(1'b1, 1'b1, 32'd294, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);

        // CPU writes, each followed by a back-to-back VGA read of the pixel.
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd294, 8'h1C, gv, gc);
        step(1'b1, 1'b1, 32'd294, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'd294, 8'hA5, gv, gc);
        step(1'b1, 1'b1, 32'd294, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);

        // CPU read just past the end of the framebuffer, then CPU read-back.
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'(FB_DEPTH), 8'h00, gv, gc);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd294, 8'h00, gv, gc);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);

        // Two VGA reads in flight when reset hits: neither may respond.
        step(1'b1, 1'b1, 32'd10, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);
        step(1'b1, 1'b1, 32'd11, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);

        // Randomized traffic: requests held until granted, rare resets.
        vp = 1'b0; cp = 1'b0; cw = 1'b0; va = '0; ca = '0; cd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!vp && $urandom_range(0, 2) != 0) begin
                vp = 1'b1;
                va = rand_addr();
            end
            if (!cp && $urandom_range(0, 2) == 0) begin
                cp = 1'b1;
                cw = 1'($urandom_range(0, 1));
                ca = rand_addr();
                cd = 8'($urandom);
            end
            rn = ($urandom_range(0, 127) != 0);
            step(rn, vp, va, cp, cw, ca, cd, gv, gc);
            if (gv) vp = 1'b0;
            if (gc) cp = 1'b0;
        end

        repeat (6) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 8'h00, gv, gc);
        chk("resp_queue_drained", 32'(rq.size()), 32'(0));
        chk("mem_queue_drained",  32'(mq.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
